pipe_hazard_ctrl: RTL and testbench

//  Sequencer for the IF/ID and ID/EX pipeline registers of the 19-bit-instruction / 12-bit-PC core.

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX/memory stages and pipe_hazard_ctrl.
// master: the pipeline side that reports hazard sources and consumes controls.
// slave : the hazard controller itself.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              branch_taken;
    logic              imem_ready;
    logic              dmem_busy;

    logic              pc_write;
    logic              stall_ifid;
    logic              flush_ifid;
    logic              bubble_idex;
    logic              stall_idex;
    logic              stall_exmem;
    logic [1:0]        state_o;
    logic              timeout_err;
    logic [15:0]       perf_stall_cnt;
    logic [15:0]       perf_flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               branch_taken, imem_ready, dmem_busy,
        input  pc_write, stall_ifid, flush_ifid, bubble_idex, stall_idex,
               stall_exmem, state_o, timeout_err, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
               branch_taken, imem_ready, dmem_busy,
        output pc_write, stall_ifid, flush_ifid, bubble_idex, stall_idex,
               stall_exmem, state_o, timeout_err, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID and ID/EX sequencer for the 19-bit-instruction core.
// Handles load-use stalls, taken-branch flushes, fetch not-ready and data-memory
// busy waits with a RUN / FLUSH / DMEM_WAIT FSM and a sticky wait timeout.
// Optional feature macro: PERF_CNT_EN (saturating 16-bit stall/flush counters).
// Outputs are Mealy: decoded from the registered state and the current inputs.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0]  ST_RUN       = 2'd0;
    localparam logic [1:0]  ST_FLUSH     = 2'd1;
    localparam logic [1:0]  ST_DMEM_WAIT = 2'd2;

    localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

    logic [1:0]        r_state;
    logic [3:0]        r_flush_cnt;
    logic [15:0]       r_wait_cnt;
    logic              r_timeout_err;

    logic [1:0]        w_state_next;
    logic [3:0]        w_flush_cnt_next;
    logic [15:0]       w_wait_cnt_next;
    logic              w_timeout_next;
    logic              w_run_decode;

    logic              w_pc_write;
    logic              w_stall_ifid;
    logic              w_flush_ifid;
    logic              w_bubble_idex;
    logic              w_stall_idex;
    logic              w_stall_exmem;

    logic [REG_AW-1:0] w_id_rs;
    logic [REG_AW-1:0] w_id_rt;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_load_use;

    assign w_id_rs = bus.id_rs;
    assign w_id_rt = bus.id_rt;
    assign w_ex_rd = bus.ex_rd;

    // R0 is hardwired zero, so a load targeting it can never create a hazard.
    assign w_load_use = bus.ex_mem_read && (w_ex_rd != '0) &&
                        ((w_ex_rd == w_id_rs) || (bus.id_uses_rt && (w_ex_rd == w_id_rt)));

    // Output decode and next-state / next-counter computation.
    always_comb begin
        w_pc_write       = 1'b1;
        w_stall_ifid     = 1'b0;
        w_flush_ifid     = 1'b0;
        w_bubble_idex    = 1'b0;
        w_stall_idex     = 1'b0;
        w_stall_exmem    = 1'b0;
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_timeout_next   = r_timeout_err;
        w_run_decode     = 1'b0;

        case (r_state)
            ST_FLUSH: begin
                if (bus.dmem_busy) begin
                    // Freeze the whole pipe; the flush resumes once memory is free.
                    w_pc_write    = 1'b0;
                    w_stall_ifid  = 1'b1;
                    w_stall_idex  = 1'b1;
                    w_stall_exmem = 1'b1;
                end else begin
                    w_flush_ifid  = 1'b1;
                    w_bubble_idex = 1'b1;
                    if (bus.branch_taken) begin
                        w_flush_cnt_next = FLUSH_LOAD;
                    end else if (r_flush_cnt <= 4'd1) begin
                        w_state_next     = ST_RUN;
                        w_flush_cnt_next = 4'd0;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt - 4'd1;
                    end
                end
            end
            ST_DMEM_WAIT: begin
                if (bus.dmem_busy) begin
                    w_pc_write    = 1'b0;
                    w_stall_ifid  = 1'b1;
                    w_stall_idex  = 1'b1;
                    w_stall_exmem = 1'b1;
                    if (r_wait_cnt < TIMEOUT_VAL) begin
                        w_wait_cnt_next = r_wait_cnt + 16'd1;
                    end
                    if (r_wait_cnt == TIMEOUT_VAL) begin
                        w_timeout_next = 1'b1;
                    end
                end else begin
                    // Memory finished: this cycle already behaves as a RUN cycle.
                    w_run_decode    = 1'b1;
                    w_wait_cnt_next = 16'd0;
                end
            end
            default: begin
                w_run_decode = 1'b1;
            end
        endcase

        if (w_run_decode) begin
            w_state_next = ST_RUN;
            if (bus.dmem_busy) begin
                w_pc_write      = 1'b0;
                w_stall_ifid    = 1'b1;
                w_stall_idex    = 1'b1;
                w_stall_exmem   = 1'b1;
                w_state_next    = ST_DMEM_WAIT;
                w_wait_cnt_next = 16'd1;
            end else if (bus.branch_taken) begin
                // Branch beats load-use: the instruction carrying the hazard is flushed.
                w_pc_write    = 1'b1;
                w_flush_ifid  = 1'b1;
                w_bubble_idex = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = FLUSH_LOAD;
                end
            end else if (w_load_use) begin
                w_pc_write    = 1'b0;
                w_stall_ifid  = 1'b1;
                w_bubble_idex = 1'b1;
            end else if (!bus.imem_ready) begin
                w_pc_write   = 1'b0;
                w_flush_ifid = 1'b1;
            end
        end
    end

    // FSM state, flush/wait counters and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_flush_cnt   <= 4'd0;
            r_wait_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_flush_cnt   <= w_flush_cnt_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_timeout_err <= w_timeout_next;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.stall_ifid  = w_stall_ifid;
    assign bus.flush_ifid  = w_flush_ifid;
    assign bus.bubble_idex = w_bubble_idex;
    assign bus.stall_idex  = w_stall_idex;
    assign bus.stall_exmem = w_stall_exmem;
    assign bus.state_o     = r_state;
    assign bus.timeout_err = r_timeout_err;

`ifdef PERF_CNT_EN
    logic [15:0] r_perf_stall_cnt;
    logic [15:0] r_perf_flush_cnt;

    // Saturating event counters for IF/ID stall and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= 16'h0000;
            r_perf_flush_cnt <= 16'h0000;
        end else begin
            if (w_stall_ifid && (r_perf_stall_cnt != 16'hFFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
            end
            if (w_flush_ifid && (r_perf_flush_cnt != 16'hFFFF)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall_cnt;
    assign bus.perf_flush_cnt = r_perf_flush_cnt;
`else
    assign bus.perf_stall_cnt = 16'h0000;
    assign bus.perf_flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table of per-cycle vectors with expected
// Mealy outputs, checked through a scoreboard queue, plus hand-written
// sequences for perf counters and asynchronous reset mid-operation.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW       = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int TIMEOUT      = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW       (REG_AW),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Output vector layout: {pc_write, stall_ifid, flush_ifid, bubble_idex,
    //                        stall_idex, stall_exmem, state_o[1:0], timeout_err}
    typedef struct {
        string      name;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [2:0] rd;
        logic       br;
        logic       rdy;
        logic       busy;
        logic [8:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [8:0]  exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_stall_total = 0;
    int          exp_flush_total = 0;

    function automatic logic [8:0] o(input int pc, input int si, input int fi, input int bi,
                                     input int sx, input int se, input int st, input int to);
        logic [1:0] st2;
        st2 = 2'(st);
        return {pc[0], si[0], fi[0], bi[0], sx[0], se[0], st2, to[0]};
    endfunction

    function automatic void add(input string nm, input int rs, input int rt, input int uses,
                                input int mr, input int rd, input int br, input int rdy,
                                input int busy, input logic [8:0] e);
        vec_t v;
        v.name     = nm;
        v.rs       = 3'(rs);
        v.rt       = 3'(rt);
        v.uses_rt  = uses[0];
        v.mem_read = mr[0];
        v.rd       = 3'(rd);
        v.br       = br[0];
        v.rdy      = rdy[0];
        v.busy     = busy[0];
        v.exp      = e;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        bus.id_rs        = v.rs;
        bus.id_rt        = v.rt;
        bus.id_uses_rt   = v.uses_rt;
        bus.ex_mem_read  = v.mem_read;
        bus.ex_rd        = v.rd;
        bus.branch_taken = v.br;
        bus.imem_ready   = v.rdy;
        bus.dmem_busy    = v.busy;
    endtask

    task automatic drive_idle();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_rd        = '0;
        bus.branch_taken = 1'b0;
        bus.imem_ready   = 1'b1;
        bus.dmem_busy    = 1'b0;
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic sb_check();
        logic [8:0] got;
        logic [8:0] e;
        string      nm;
        got = {bus.pc_write, bus.stall_ifid, bus.flush_ifid, bus.bubble_idex,
               bus.stall_idex, bus.stall_exmem, bus.state_o, bus.timeout_err};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty got=%b", got);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s got=%b required=%b (pc,si,fi,bi,sx,se,st,to)", nm, got, e);
            end else begin
                $display("ok   %s out=%b", nm, got);
            end
        end
    endtask

    task automatic check_now(input string nm, input logic [8:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        sb_check();
    endtask

    task automatic check_perf(input string nm, input int stall_exp, input int flush_exp);
        n_checks++;
        if (bus.perf_stall_cnt !== 16'(stall_exp)) begin
            n_fail++;
            $display("FAIL %s_stall got=%0d required=%0d", nm, bus.perf_stall_cnt, stall_exp);
        end else begin
            $display("ok   %s_stall cnt=%0d", nm, bus.perf_stall_cnt);
        end
        n_checks++;
        if (bus.perf_flush_cnt !== 16'(flush_exp)) begin
            n_fail++;
            $display("FAIL %s_flush got=%0d required=%0d", nm, bus.perf_flush_cnt, flush_exp);
        end else begin
            $display("ok   %s_flush cnt=%0d", nm, bus.perf_flush_cnt);
        end
    endtask

    // One clock cycle per vector: drive after the edge, check mid-cycle.
    task automatic apply(input vec_t v);
        drive(v);
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] idle0;
        logic [8:0] idle1;
        logic [8:0] stall_st;
        logic [8:0] flush_run;
        logic [8:0] flush_fl;
        int         ps;
        int         pf;

        idle0     = o(1, 0, 0, 0, 0, 0, 0, 0);
        idle1     = o(1, 0, 0, 0, 0, 0, 0, 1);
        flush_run = o(1, 0, 1, 1, 0, 0, 0, 0);
        flush_fl  = o(1, 0, 1, 1, 0, 0, 1, 0);
        stall_st  = o(0, 1, 0, 1, 0, 0, 0, 0);

        // name            rs rt u  mr rd br rdy busy  expected
        add("idle_a",        0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("idle_b",        0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("lu_rs",         3, 0, 0, 1, 3, 0, 1, 0, stall_st);
        add("lu_rs_after",   0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("lu_rd0",        0, 0, 0, 1, 0, 0, 1, 0, idle0);
        add("lu_rt",         2, 5, 1, 1, 5, 0, 1, 0, stall_st);
        add("lu_rt_unused",  2, 5, 0, 1, 5, 0, 1, 0, idle0);
        add("no_load",       3, 0, 0, 0, 3, 0, 1, 0, idle0);
        add("imem_nr",       0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 0, 0));
        add("branch",        0, 0, 0, 0, 0, 1, 1, 0, flush_run);
        add("flush_2nd",     0, 0, 0, 0, 0, 0, 1, 0, flush_fl);
        add("post_flush",    0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("br_and_lu",     3, 0, 0, 1, 3, 1, 1, 0, flush_run);
        add("flush_ign_lu",  3, 0, 0, 1, 3, 0, 1, 0, flush_fl);
        add("post_flush_b",  0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("branch_r",      0, 0, 0, 0, 0, 1, 1, 0, flush_run);
        add("flush_reload",  0, 0, 0, 0, 0, 1, 1, 0, flush_fl);
        add("flush_tail",    0, 0, 0, 0, 0, 0, 1, 0, flush_fl);
        add("post_reload",   0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("branch_f",      0, 0, 0, 0, 0, 1, 1, 0, flush_run);
        add("flush_busy",    0, 0, 0, 0, 0, 0, 1, 1, o(0, 1, 0, 0, 1, 1, 1, 0));
        add("flush_resume",  0, 0, 0, 0, 0, 0, 1, 0, flush_fl);
        add("post_fbusy",    0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("busy5_0",       0, 0, 0, 0, 0, 0, 1, 1, o(0, 1, 0, 0, 1, 1, 0, 0));
        for (int i = 1; i < 5; i++)
            add($sformatf("busy5_%0d", i), 0, 0, 0, 0, 0, 0, 1, 1, o(0, 1, 0, 0, 1, 1, 2, 0));
        add("busy5_rel_nr",  0, 0, 0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 0, 2, 0));
        add("post_busy5",    0, 0, 0, 0, 0, 0, 1, 0, idle0);
        add("busy10_0",      0, 0, 0, 0, 0, 0, 1, 1, o(0, 1, 0, 0, 1, 1, 0, 0));
        for (int i = 1; i < 10; i++)
            add($sformatf("busy10_%0d", i), 0, 0, 0, 0, 0, 0, 1, 1,
                o(0, 1, 0, 0, 1, 1, 2, (i > TIMEOUT) ? 1 : 0));
        add("busy10_rel",    0, 0, 0, 0, 0, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 2, 1));
        add("to_sticky",     0, 0, 0, 0, 0, 0, 1, 0, idle1);
        add("to_sticky_lu",  4, 0, 0, 1, 4, 0, 1, 0, o(0, 1, 0, 1, 0, 0, 0, 1));
        add("to_sticky_end", 0, 0, 0, 0, 0, 0, 1, 0, idle1);

        foreach (vecs[i]) begin
            exp_stall_total += int'(vecs[i].exp[7]);
            exp_flush_total += int'(vecs[i].exp[6]);
        end
`ifdef PERF_CNT_EN
        ps = exp_stall_total;
        pf = exp_flush_total;
`else
        ps = 0;
        pf = 0;
`endif

        // Reset state
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        check_now("reset", idle0);
        check_perf("perf_reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        check_perf("perf_total", ps, pf);

        // Asynchronous reset in the middle of a DMEM wait with timeout_err set.
        begin
            vec_t v;
            v.name = "pre_rst_busy0"; v.rs = 0; v.rt = 0; v.uses_rt = 0; v.mem_read = 0;
            v.rd = 0; v.br = 0; v.rdy = 1; v.busy = 1; v.exp = o(0, 1, 0, 0, 1, 1, 0, 1);
            apply(v);
            v.name = "pre_rst_busy1"; v.exp = o(0, 1, 0, 0, 1, 1, 2, 1);
            apply(v);
            drive_idle();
            #2;
            rst = 1'b1;
            #1;
            check_now("async_rst", idle0);
            check_perf("perf_async_rst", 0, 0);
            @(negedge clk);
            check_now("rst_held", idle0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            v.name = "post_rst_busy"; v.exp = o(0, 1, 0, 0, 1, 1, 0, 0);
            apply(v);
            v.name = "post_rst_rel"; v.busy = 0; v.exp = o(1, 0, 0, 0, 0, 0, 2, 0);
            apply(v);
            v.name = "post_rst_idle"; v.exp = idle0;
            apply(v);
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
